// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode encodings and the byte-sequencer state encoding.
// Pure declarations; no logic, no latency, no flow control.
// Imported by alu_uart_ctrl and alu_op_valid.
package alu_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_OP_DEF   = 6;

    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

endpackage

// File: rtl/alu_op_valid.sv
// Opcode membership check: valid is high when op is one of the eight supported ALU opcodes.
// Latency: purely combinational.
// Backpressure: none, evaluated every cycle.
module alu_op_valid
    import alu_pkg::*;
#(
    parameter int NB_OP = NB_OP_DEF
) (
    input  logic [NB_OP-1:0] op,
    output logic             valid
);

    always_comb begin
        valid = 1'b0;
        case (op)
            NB_OP'(OP_ADD), NB_OP'(OP_SUB), NB_OP'(OP_AND), NB_OP'(OP_OR),
            NB_OP'(OP_XOR), NB_OP'(OP_SRA), NB_OP'(OP_SRL), NB_OP'(OP_NOR): valid = 1'b1;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_uart_ctrl.sv
// Collects A, B, opcode from rx bytes, runs the ALU, hands the result to tx (OPCODE_CHECK_EN rejects unknown ops).
// Latency: opcode byte at edge N -> EXEC in N+1 -> o_tx_data valid with o_tx_start pulse in N+2.
// Backpressure: none on rx (bytes outside the collect states are dropped); waits indefinitely for i_tx_done.
module alu_uart_ctrl
    import alu_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_error
);

    state_t state;
    state_t state_nxt;
    logic   op_ok;
    logic   load_a;
    logic   load_b;
    logic   load_op;
    logic   load_tx;
    logic   op_err;

`ifdef OPCODE_CHECK_EN
    alu_op_valid #(
        .NB_OP (NB_OP)
    ) u_op_valid (
        .op    (i_rx_data[NB_OP-1:0]),
        .valid (op_ok)
    );
`else
    assign op_ok = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        load_a    = 1'b0;
        load_b    = 1'b0;
        load_op   = 1'b0;
        load_tx   = 1'b0;
        op_err    = 1'b0;
        case (state)
            IDLE: begin
                if (i_rx_done) begin
                    load_a    = 1'b1;
                    state_nxt = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    load_b    = 1'b1;
                    state_nxt = WAIT_OP;
                end
            end
            WAIT_OP: begin
                // A rejected opcode leaves the previous o_alu_op on the ALU.
                if (i_rx_done) begin
                    if (op_ok) begin
                        load_op   = 1'b1;
                        state_nxt = EXEC;
                    end else begin
                        op_err    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            EXEC: begin
                load_tx   = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= IDLE;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_tx_start <= (state_nxt == SEND);
            o_busy     <= (state_nxt != IDLE);
            o_error    <= op_err;
            if (load_a) begin
                o_alu_a <= i_rx_data;
            end
            if (load_b) begin
                o_alu_b <= i_rx_data;
            end
            if (load_op) begin
                o_alu_op <= i_rx_data[NB_OP-1:0];
            end
            if (load_tx) begin
                o_tx_data <= i_alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Testbench for alu_uart_ctrl: directed byte sequences plus randomized transactions against a reference model.
// The ALU is modelled in the bench and fed from the DUT's registered operand outputs.
module tb_alu_uart_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;
    logic       busy;
    logic       error;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] obs_tx;
    int         obs_pulses;
    int         obs_first;
    int         obs_errs;
    logic       obs_busy_exec;
    logic       obs_busy_hold;
    logic       obs_busy_after;

    logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};

    always #5 clk = ~clk;

    alu_uart_ctrl #(
        .NB_DATA (8),
        .NB_OP   (6)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .i_alu_result (alu_result),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .i_tx_done    (tx_done),
        .o_busy       (busy),
        .o_error      (error)
    );

    // Reference ALU; unknown opcodes yield a recognisable marker byte.
    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b000011: return 8'($signed(a) >>> b);
            6'b000010: return a >> b;
            6'b100111: return ~(a | b);
            default:   return 8'hEE;
        endcase
    endfunction

    assign alu_result = ref_alu(alu_a, alu_b, alu_op);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    // Drives one full transaction and records what the DUT did. Sample index c=0 is the cycle right
    // after the opcode byte was taken (EXEC); c=1 is the cycle where o_tx_start must be high.
    // stray_at 0..3 injects a 0x55 byte at that sample index, 4 injects it together with i_tx_done.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input int gap, input int tx_delay, input int stray_at);
        send_byte(a);
        repeat (gap) tick();
        send_byte(b);
        repeat (gap) tick();
        send_byte(op);
        obs_pulses    = 0;
        obs_first     = -1;
        obs_errs      = 0;
        obs_tx        = 8'h00;
        obs_busy_exec = busy;
        for (int c = 0; c < 4; c++) begin
            if (tx_start) begin
                obs_pulses++;
                if (obs_first < 0) obs_first = c;
                obs_tx = tx_data;
            end
            if (error) obs_errs++;
            if (c == stray_at) begin
                rx_data = 8'h55;
                rx_done = 1'b1;
            end
            tick();
            rx_done = 1'b0;
        end
        obs_busy_hold = busy;
        if (obs_errs == 0) begin
            repeat (tx_delay) tick();
            obs_busy_hold = busy;
            tx_done = 1'b1;
            if (stray_at == 4) begin
                rx_data = 8'h55;
                rx_done = 1'b1;
            end
            tick();
            tx_done = 1'b0;
            rx_done = 1'b0;
        end
        obs_busy_after = busy;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        rx_data = 8'hAB;
        rx_done = 1'b1;
        tx_done = 1'b1;
        tick();
        tick();
        n_checks++; if (alu_a !== 8'h00) $display("FAIL reset_alu_a: got %0h want 0", alu_a); else n_pass++;
        n_checks++; if (alu_b !== 8'h00) $display("FAIL reset_alu_b: got %0h want 0", alu_b); else n_pass++;
        n_checks++; if (alu_op !== 6'h00) $display("FAIL reset_alu_op: got %0h want 0", alu_op); else n_pass++;
        n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %0h want 0", tx_data); else n_pass++;
        n_checks++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %0b want 0", tx_start); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL reset_error: got %0b want 0", error); else n_pass++;
        rst     = 1'b0;
        rx_done = 1'b0;
        tx_done = 1'b0;
        tick();
    endtask

    task automatic test_add();
        run_txn(8'h80, 8'h03, 8'h20, 0, 10, -1);
        n_checks++; if (obs_tx !== 8'h83) $display("FAIL add_tx_data: got %0h want 83", obs_tx); else n_pass++;
        n_checks++; if (obs_pulses !== 1) $display("FAIL add_start_pulses: got %0d want 1", obs_pulses); else n_pass++;
        n_checks++; if (obs_first !== 1) $display("FAIL add_start_cycle: got %0d want 1", obs_first); else n_pass++;
        n_checks++; if (obs_busy_exec !== 1'b1) $display("FAIL add_busy_exec: got %0b want 1", obs_busy_exec); else n_pass++;
        n_checks++; if (obs_busy_hold !== 1'b1) $display("FAIL add_busy_wait_tx: got %0b want 1", obs_busy_hold); else n_pass++;
        n_checks++; if (obs_busy_after !== 1'b0) $display("FAIL add_idle_after_done: got %0b want 0", obs_busy_after); else n_pass++;
        n_checks++; if (alu_a !== 8'h80) $display("FAIL add_hold_a: got %0h want 80", alu_a); else n_pass++;
        n_checks++; if (alu_b !== 8'h03) $display("FAIL add_hold_b: got %0h want 03", alu_b); else n_pass++;
        n_checks++; if (alu_op !== 6'h20) $display("FAIL add_hold_op: got %0h want 20", alu_op); else n_pass++;
    endtask

    task automatic test_patterns();
        logic [7:0] ta  [4] = '{8'h05, 8'h80, 8'h80, 8'h80};
        logic [7:0] tb  [4] = '{8'h07, 8'h03, 8'h03, 8'h03};
        logic [7:0] top [4] = '{8'h22, 8'h27, 8'h03, 8'h02};
        logic [7:0] te  [4] = '{8'hFE, 8'h7C, 8'hF0, 8'h10};
        for (int i = 0; i < 4; i++) begin
            run_txn(ta[i], tb[i], top[i], 0, 2, -1);
            n_checks++; if (obs_tx !== te[i]) $display("FAIL pattern%0d_tx_data: got %0h want %0h", i, obs_tx, te[i]); else n_pass++;
            n_checks++; if (obs_pulses !== 1) $display("FAIL pattern%0d_pulses: got %0d want 1", i, obs_pulses); else n_pass++;
        end
    endtask

    task automatic test_drop();
        for (int s = 0; s <= 4; s++) begin
            run_txn(8'h10 + 8'(s), 8'h21, 8'h26, 1, 3, s);
            n_checks++; if (obs_tx !== ((8'h10 + 8'(s)) ^ 8'h21)) $display("FAIL drop%0d_tx_data: got %0h want %0h", s, obs_tx, (8'h10 + 8'(s)) ^ 8'h21); else n_pass++;
            n_checks++; if (obs_busy_after !== 1'b0) $display("FAIL drop%0d_idle: got %0b want 0", s, obs_busy_after); else n_pass++;
            run_txn(8'h01, 8'h02, 8'h20, 0, 1, -1);
            n_checks++; if (obs_tx !== 8'h03) $display("FAIL drop%0d_next_tx: got %0h want 03", s, obs_tx); else n_pass++;
            n_checks++; if (alu_a !== 8'h01) $display("FAIL drop%0d_next_a: got %0h want 01", s, alu_a); else n_pass++;
        end
    endtask

    task automatic test_tx_done_ignored();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL txdone_idle_busy: got %0b want 0", busy); else n_pass++;
        send_byte(8'h0C);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL txdone_wait_b_busy: got %0b want 1", busy); else n_pass++;
        send_byte(8'h0A);
        send_byte(8'h24);
        tick();
        n_checks++; if (tx_start !== 1'b1) $display("FAIL txdone_start: got %0b want 1", tx_start); else n_pass++;
        n_checks++; if (tx_data !== 8'h08) $display("FAIL txdone_tx_data: got %0h want 08", tx_data); else n_pass++;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL txdone_final_idle: got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        send_byte(8'h11);
        send_byte(8'h22);
        rst     = 1'b1;
        rx_data = 8'h20;
        rx_done = 1'b1;
        tick();
        rst     = 1'b0;
        rx_done = 1'b0;
        n_checks++; if (alu_a !== 8'h00) $display("FAIL midrst_alu_a: got %0h want 0", alu_a); else n_pass++;
        n_checks++; if (alu_b !== 8'h00) $display("FAIL midrst_alu_b: got %0h want 0", alu_b); else n_pass++;
        n_checks++; if (alu_op !== 6'h00) $display("FAIL midrst_alu_op: got %0h want 0", alu_op); else n_pass++;
        n_checks++; if (tx_data !== 8'h00) $display("FAIL midrst_tx_data: got %0h want 0", tx_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %0b want 0", busy); else n_pass++;
        tick();
        n_checks++; if (busy !== 1'b0 || tx_start !== 1'b0) $display("FAIL midrst_stays_idle: got busy=%0b start=%0b want 0/0", busy, tx_start); else n_pass++;
        run_txn(8'h01, 8'h01, 8'h24, 0, 2, -1);
        n_checks++; if (obs_tx !== 8'h01) $display("FAIL midrst_and_tx: got %0h want 01", obs_tx); else n_pass++;
    endtask

    task automatic test_opcode_check();
        run_txn(8'h80, 8'h03, 8'h20, 0, 1, -1);
        run_txn(8'h44, 8'h12, 8'h3F, 0, 2, -1);
`ifdef OPCODE_CHECK_EN
        n_checks++; if (obs_errs !== 1) $display("FAIL opchk_error_pulses: got %0d want 1", obs_errs); else n_pass++;
        n_checks++; if (obs_pulses !== 0) $display("FAIL opchk_no_tx: got %0d want 0", obs_pulses); else n_pass++;
        n_checks++; if (alu_op !== 6'h20) $display("FAIL opchk_op_kept: got %0h want 20", alu_op); else n_pass++;
        n_checks++; if (obs_busy_exec !== 1'b0) $display("FAIL opchk_busy: got %0b want 0", obs_busy_exec); else n_pass++;
`else
        n_checks++; if (obs_errs !== 0) $display("FAIL opchk_error_pulses: got %0d want 0", obs_errs); else n_pass++;
        n_checks++; if (obs_pulses !== 1) $display("FAIL opchk_tx: got %0d want 1", obs_pulses); else n_pass++;
        n_checks++; if (alu_op !== 6'h3F) $display("FAIL opchk_op_fwd: got %0h want 3f", alu_op); else n_pass++;
        n_checks++; if (obs_tx !== 8'hEE) $display("FAIL opchk_tx_data: got %0h want ee", obs_tx); else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] exp;
        for (int t = 0; t < 40; t++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = {2'($urandom), valid_ops[$urandom_range(0, 7)]};
            exp = ref_alu(a, b, op[5:0]);
            run_txn(a, b, op, $urandom_range(0, 2), $urandom_range(0, 6), int'($urandom_range(0, 5)) - 1);
            n_checks++; if (obs_tx !== exp) $display("FAIL rand%0d_tx_data: got %0h want %0h", t, obs_tx, exp); else n_pass++;
            n_checks++; if (obs_pulses !== 1 || obs_first !== 1) $display("FAIL rand%0d_start: got %0d pulses at %0d want 1 at 1", t, obs_pulses, obs_first); else n_pass++;
            n_checks++; if (obs_busy_after !== 1'b0) $display("FAIL rand%0d_idle: got %0b want 0", t, obs_busy_after); else n_pass++;
            n_checks++; if (alu_a !== a || alu_b !== b) $display("FAIL rand%0d_operands: got %0h/%0h want %0h/%0h", t, alu_a, alu_b, a, b); else n_pass++;
            n_checks++; if (alu_op !== op[5:0]) $display("FAIL rand%0d_op: got %0h want %0h", t, alu_op, op[5:0]); else n_pass++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        test_reset();
        test_add();
        test_patterns();
        test_drop();
        test_tx_done_ignored();
        test_reset_mid();
        test_opcode_check();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running at %0t, limit 500000", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_uart_ctrl.md
Name: alu_uart_ctrl

Overview:
- Byte-stream sequencer that feeds the shared ALU from a serial receiver instead of switches and buttons.
- Collects operand A, operand B and the opcode as three consecutive received bytes, drives them onto the ALU, captures the result and hands it to the transmitter with a start/done handshake.
- Sits between uart_rx/uart_tx and the ALU inside the top level; replaces the btnAA/btnBB/btnOP1 loading path.

Parameters:
NB_DATA, 8, width of operands, result, rx byte and tx byte
NB_OP, 6, ALU opcode width; low NB_OP bits of the opcode byte are used

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_rx_data  in  NB_DATA  received byte, valid while i_rx_done is high
i_rx_done  in  1  one-cycle pulse, new byte available
o_alu_a  out  NB_DATA  operand A to ALU (registered)
o_alu_b  out  NB_DATA  operand B to ALU (registered)
o_alu_op  out  NB_OP  opcode to ALU (registered)
i_alu_result  in  NB_DATA  combinational ALU result
o_tx_data  out  NB_DATA  result byte to transmitter (registered)
o_tx_start  out  1  one-cycle pulse, start transmission
i_tx_done  in  1  one-cycle pulse, transmitter finished
o_busy  out  1  high in every state except IDLE
o_error  out  1  one-cycle pulse, invalid opcode (OPCODE_CHECK_EN only)

Behaviour:
- Reset, synchronous on i_clock when i_reset=1:
  - state=IDLE.
  - o_alu_a, o_alu_b, o_tx_data = 0; o_alu_op = 0.
  - o_tx_start, o_busy, o_error = 0.
  - Reset wins over every other input in the same cycle.
- IDLE: on i_rx_done, o_alu_a<=i_rx_data, go to WAIT_B.
- WAIT_B: on i_rx_done, o_alu_b<=i_rx_data, go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_alu_op<=i_rx_data[NB_OP-1:0], go to EXEC.
- EXEC: single cycle; ALU inputs are stable. At the edge, o_tx_data<=i_alu_result, go to SEND.
- SEND: o_tx_start=1 for exactly this cycle (registered), go to WAIT_TX.
- WAIT_TX: hold until i_tx_done, then go to IDLE.
- Latency:
  - opcode-byte i_rx_done at edge N -> EXEC in cycle N+1 -> o_tx_data valid and o_tx_start high in cycle N+2.
  - IDLE is re-entered the cycle after i_tx_done.
- Operand hold: o_alu_a, o_alu_b and o_alu_op keep their last values after the transaction until overwritten, so the ALU output stays observable.
- i_rx_done in EXEC, SEND or WAIT_TX: byte dropped, no state change; no queueing.
- i_tx_done outside WAIT_TX: ignored.
- i_tx_done and i_rx_done in the same cycle in WAIT_TX: go to IDLE; the rx byte is dropped.
- No timeout: the block waits indefinitely in WAIT_B, WAIT_OP and WAIT_TX.
- Reset mid-transaction aborts the transaction; partial operands are cleared.
- Width: result is truncated to NB_DATA; carry is not transported.

Optional Feature:
- Macro: OPCODE_CHECK_EN.
- Defined:
  - In WAIT_OP, an opcode not in {ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111} gives o_error=1 for one cycle and a return to IDLE.
  - o_alu_op is not updated and no tx occurs.
- Undefined:
  - Every opcode is forwarded to the ALU.
  - o_error is tied to 0.

Decomposition:
- Package alu_pkg:
  - opcode localparams ADD, SUB, AND, OR, XOR, SRA, SRL, NOR;
  - state encoding IDLE, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX (3-bit);
  - NB_DATA/NB_OP defaults.
- Sub-module alu_op_valid: combinational opcode membership check, instantiated only under OPCODE_CHECK_EN.

Test Plan:
- Bytes 0x80, 0x03, 0x20 (ADD), then i_tx_done after 10 cycles -> o_alu_a=0x80, o_alu_b=0x03, o_tx_data=0x83, one o_tx_start pulse 2 cycles after the op byte, then IDLE.
- Bytes 0x05, 0x07, 0x22 (SUB) -> o_tx_data=0xFE; bytes 0x80, 0x03, 0x27 (NOR) -> o_tx_data=0x7C.
- Bytes 0x80, 0x03, 0x03 (SRA) -> o_tx_data=0xF0; same operands with 0x02 (SRL) -> 0x10.
- Extra byte 0x55 sent during WAIT_TX -> dropped; the next transaction 0x01, 0x02, 0x20 gives 0x03 and o_alu_a is not 0x55.
- Reset asserted in WAIT_OP after 0x11, 0x22 -> next cycle all outputs 0, state IDLE; a fresh 0x01, 0x01, 0x24 (AND) gives 0x01.
- With OPCODE_CHECK_EN, op byte 0x3F -> o_error pulse, no o_tx_start, o_alu_op unchanged, o_busy=0 the next cycle; without the macro, the same byte is forwarded and tx occurs.
